mod_counter_gen: RTL and testbench

- Parametrised modulo-N up/down counter clocked from the slow game tick (clk_1H). It is the general successor to the fixed 3-bit wrap counters.
- Uses in the VGA game: score digits, countdown timers and sprite frame indices.
- Supports enable, direction, synchronous clear and load, wrap or one-shot (saturating) mode, and a cascade carry so that digits chain into multi-digit counters.

---
 rtl/mod_counter_gen.sv | 145 ++++++++++++++
 tb/tb_mod_counter_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_gen.sv
// -----------------------------------------------------------------------------
// mod_counter_gen
//   Parametrised modulo-MODULO up/down counter on the slow game tick (clk_1H).
//   It drives score digits, countdown timers and sprite frame indices. Digits
//   chain into multi-digit counters by tying the next digit's en to carry_out.
//
// Parameters
//   WIDTH    bit width of count_out / load_val (2**WIDTH >= MODULO)
//   MODULO   count range 0..MODULO-1 (2..2**WIDTH)
//   INIT     value loaded by reset (< MODULO)
//   ONE_SHOT 0 = wrap at the terminal value, 1 = stop there and raise done
//
// Ports
//   clk_1H     in   count clock, all state changes on the rising edge
//   reset      in   synchronous, active-high
//   en         in   count enable (qualifies stepping only)
//   up_dn      in   1 = up, 0 = down
//   clear      in   synchronous clear to 0
//   load       in   synchronous load of load_val (clamped to MODULO-1)
//   load_val   in   [WIDTH-1:0] load value
//   count_out  out  [WIDTH-1:0] registered count
//   carry_out  out  combinational cascade carry/borrow
//   done       out  registered one-shot terminal flag
//   seg_out    out  [6:0] active-low hex digit, bit 6 = a ... bit 0 = g
//                   (present only when MOD_COUNTER_SEG_DECODE_EN is defined)
//
// Per-edge priority: reset > clear > load > step > hold.
// -----------------------------------------------------------------------------
module mod_counter_gen #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 10,
    parameter int INIT     = 0,
    parameter int ONE_SHOT = 0
) (
    input  logic             clk_1H,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             done
`ifdef MOD_COUNTER_SEG_DECODE_EN
    ,
    output logic [6:0]       seg_out
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] INIT_VAL   = WIDTH'(INIT);
    // One extra bit so MODULO == 2**WIDTH is representable for the clamp test.
    localparam logic [WIDTH:0]   MODULO_EXT = (WIDTH + 1)'(MODULO);
    localparam bit               STOP_MODE  = (ONE_SHOT != 0);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] terminal_val;
    logic             at_terminal;
    logic             stepping;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;

    // Terminal value follows the current up_dn, so a direction change at a
    // boundary is seen in the same cycle.
    assign terminal_val = up_dn ? MAX_VAL : '0;
    assign at_terminal  = (count_out == terminal_val);
    assign stepping     = en && (state == ST_RUN);

    assign load_clamped = ({1'b0, load_val} >= MODULO_EXT) ? MAX_VAL : load_val;

    assign carry_out = stepping && at_terminal && !clear && !load && !reset;

    // Next count, fully prioritised. Compare-before-step keeps the arithmetic
    // inside WIDTH bits even when MODULO == 2**WIDTH.
    always_comb begin
        // NOTE: default assignment first so every path assigns next_count and
        // no latch is inferred.
        next_count = count_out;
        if (reset) begin
            next_count = INIT_VAL;
        end else if (clear) begin
            next_count = '0;
        end else if (load) begin
            next_count = load_clamped;
        end else if (stepping && !(STOP_MODE && at_terminal)) begin
            if (up_dn) begin
                next_count = (count_out == MAX_VAL) ? '0 : count_out + WIDTH'(1);
            end else begin
                next_count = (count_out == '0) ? MAX_VAL : count_out - WIDTH'(1);
            end
        end
    end

`ifdef MOD_COUNTER_SEG_DECODE_EN
    // Active-low hex decode, bit 6 = a ... bit 0 = g. Values above 15 blank.
    function automatic logic [6:0] seg_decode(input logic [WIDTH-1:0] v);
        logic [6:0] s;
        case (int'(v))
            0:       s = 7'b0000001;
            1:       s = 7'b1001111;
            2:       s = 7'b0010010;
            3:       s = 7'b0000110;
            4:       s = 7'b1001100;
            5:       s = 7'b0100100;
            6:       s = 7'b0100000;
            7:       s = 7'b0001111;
            8:       s = 7'b0000000;
            9:       s = 7'b0000100;
            10:      s = 7'b0001000;
            11:      s = 7'b1100000;
            12:      s = 7'b0110001;
            13:      s = 7'b1000010;
            14:      s = 7'b0110000;
            15:      s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction
`endif

    // Count register, one-shot FSM and registered done flag.
    always_ff @(posedge clk_1H) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        count_out <= next_count;
`ifdef MOD_COUNTER_SEG_DECODE_EN
        // Decoding next_count keeps seg_out aligned with count_out.
        seg_out   <= seg_decode(next_count);
`endif
        if (reset || clear || load) begin
            state <= ST_RUN;
            done  <= 1'b0;
        end else if (STOP_MODE && stepping && at_terminal) begin
            state <= ST_DONE;
            done  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_counter_gen.sv
// -----------------------------------------------------------------------------
// tb_mod_counter_gen
//   Self-checking bench for mod_counter_gen. Five instances share clk_1H:
//     0 u_a   WIDTH=4 MODULO=10 INIT=0 wrap
//     1 u_b   WIDTH=4 MODULO=10 INIT=0 one-shot
//     2 u_c   WIDTH=3 MODULO=8  INIT=5 wrap (full binary range)
//     3 u_lo  cascade low digit
//     4 u_hi  cascade high digit, en = u_lo.carry_out
//   Every tick compares all carries (before the edge) and all counts/done
//   (after the edge) against a modulo-arithmetic reference model; directed
//   phases add explicit expected constants.
// -----------------------------------------------------------------------------
module tb_mod_counter_gen;

    localparam int NI = 5;

    typedef struct {
        bit rst;
        bit clr;
        bit ld;
        bit en;
        bit ud;
        int lv;
    } in_t;

    logic clk_1H = 1'b0;
    always #5 clk_1H = ~clk_1H;

    in_t in_a, in_b, in_c, in_k;

    logic [3:0] cnt_a, cnt_b, cnt_lo, cnt_hi;
    logic [2:0] cnt_c;
    logic       carry_a, carry_b, carry_c, carry_lo, carry_hi;
    logic       done_a, done_b, done_c, done_lo, done_hi;
`ifdef MOD_COUNTER_SEG_DECODE_EN
    logic [6:0] seg_a, seg_b, seg_c, seg_lo, seg_hi;
`endif

    mod_counter_gen #(.WIDTH(4), .MODULO(10), .INIT(0), .ONE_SHOT(0)) u_a (
        .clk_1H(clk_1H), .reset(in_a.rst), .en(in_a.en), .up_dn(in_a.ud),
        .clear(in_a.clr), .load(in_a.ld), .load_val(4'(in_a.lv)),
        .count_out(cnt_a), .carry_out(carry_a), .done(done_a)
`ifdef MOD_COUNTER_SEG_DECODE_EN
        , .seg_out(seg_a)
`endif
    );

    mod_counter_gen #(.WIDTH(4), .MODULO(10), .INIT(0), .ONE_SHOT(1)) u_b (
        .clk_1H(clk_1H), .reset(in_b.rst), .en(in_b.en), .up_dn(in_b.ud),
        .clear(in_b.clr), .load(in_b.ld), .load_val(4'(in_b.lv)),
        .count_out(cnt_b), .carry_out(carry_b), .done(done_b)
`ifdef MOD_COUNTER_SEG_DECODE_EN
        , .seg_out(seg_b)
`endif
    );

    mod_counter_gen #(.WIDTH(3), .MODULO(8), .INIT(5), .ONE_SHOT(0)) u_c (
        .clk_1H(clk_1H), .reset(in_c.rst), .en(in_c.en), .up_dn(in_c.ud),
        .clear(in_c.clr), .load(in_c.ld), .load_val(3'(in_c.lv)),
        .count_out(cnt_c), .carry_out(carry_c), .done(done_c)
`ifdef MOD_COUNTER_SEG_DECODE_EN
        , .seg_out(seg_c)
`endif
    );

    mod_counter_gen #(.WIDTH(4), .MODULO(10), .INIT(0), .ONE_SHOT(0)) u_lo (
        .clk_1H(clk_1H), .reset(in_k.rst), .en(in_k.en), .up_dn(in_k.ud),
        .clear(in_k.clr), .load(in_k.ld), .load_val(4'(in_k.lv)),
        .count_out(cnt_lo), .carry_out(carry_lo), .done(done_lo)
`ifdef MOD_COUNTER_SEG_DECODE_EN
        , .seg_out(seg_lo)
`endif
    );

    mod_counter_gen #(.WIDTH(4), .MODULO(10), .INIT(0), .ONE_SHOT(0)) u_hi (
        .clk_1H(clk_1H), .reset(in_k.rst), .en(carry_lo), .up_dn(in_k.ud),
        .clear(in_k.clr), .load(in_k.ld), .load_val(4'(in_k.lv)),
        .count_out(cnt_hi), .carry_out(carry_hi), .done(done_hi)
`ifdef MOD_COUNTER_SEG_DECODE_EN
        , .seg_out(seg_hi)
`endif
    );

    // ---------------- reference model ----------------
    int mod_p  [NI] = '{10, 10, 8, 10, 10};
    int init_p [NI] = '{0, 0, 5, 0, 0};
    int os_p   [NI] = '{0, 1, 0, 0, 0};
    int width_p[NI] = '{4, 4, 3, 4, 4};
    int m_cnt  [NI];
    bit m_done [NI];

    // Active-low hex table, bit 6 = a ... bit 0 = g.
    logic [6:0] seg_tab[16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_checks   = 0;
    int n_failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int term_of(input int k, input bit ud);
        return ud ? mod_p[k] - 1 : 0;
    endfunction

    function automatic bit model_carry(input int k, input in_t i);
        return i.en && !m_done[k] && (m_cnt[k] == term_of(k, i.ud))
               && !i.clr && !i.ld && !i.rst;
    endfunction

    task automatic model_edge(input int k, input in_t i);
        int lv;
        lv = i.lv & ((1 << width_p[k]) - 1);
        if (i.rst) begin
            m_cnt[k] = init_p[k];  m_done[k] = 1'b0;
        end else if (i.clr) begin
            m_cnt[k] = 0;          m_done[k] = 1'b0;
        end else if (i.ld) begin
            m_cnt[k] = (lv >= mod_p[k]) ? mod_p[k] - 1 : lv;
            m_done[k] = 1'b0;
        end else if (i.en && !m_done[k]) begin
            if (os_p[k] != 0 && m_cnt[k] == term_of(k, i.ud))
                m_done[k] = 1'b1;
            else if (i.ud)
                m_cnt[k] = (m_cnt[k] + 1) % mod_p[k];
            else
                m_cnt[k] = (m_cnt[k] + mod_p[k] - 1) % mod_p[k];
        end
    endtask

    // One clock: carries checked before the edge, state checked after it.
    task automatic tick();
        in_t        iv[NI];
        bit         cy[NI];
        logic [3:0] gc[NI];
        logic       gy[NI];
        logic       gd[NI];
        @(negedge clk_1H);
        iv[0] = in_a; iv[1] = in_b; iv[2] = in_c; iv[3] = in_k; iv[4] = in_k;
        for (int k = 0; k < NI; k++) begin
            if (k == 4) iv[4].en = cy[3];
            cy[k] = model_carry(k, iv[k]);
        end
        gy[0] = carry_a; gy[1] = carry_b; gy[2] = carry_c; gy[3] = carry_lo; gy[4] = carry_hi;
        for (int k = 0; k < NI; k++) check($sformatf("carry%0d", k), gy[k], cy[k]);
        @(posedge clk_1H);
        #1;
        for (int k = 0; k < NI; k++) model_edge(k, iv[k]);
        gc[0] = cnt_a; gc[1] = cnt_b; gc[2] = {1'b0, cnt_c}; gc[3] = cnt_lo; gc[4] = cnt_hi;
        gd[0] = done_a; gd[1] = done_b; gd[2] = done_c; gd[3] = done_lo; gd[4] = done_hi;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("count%0d", k), gc[k], m_cnt[k]);
            check($sformatf("done%0d", k), gd[k], m_done[k]);
        end
`ifdef MOD_COUNTER_SEG_DECODE_EN
        check("seg_a", seg_a, seg_tab[m_cnt[0]]);
`endif
    endtask

    function automatic in_t rnd_in(input int w);
        in_t r;
        r.rst = ($urandom_range(0, 31) == 0);
        r.clr = ($urandom_range(0, 11) == 0);
        r.ld  = ($urandom_range(0, 9) == 0);
        r.en  = ($urandom_range(0, 3) != 0);
        r.ud  = 1'($urandom_range(0, 1));
        r.lv  = int'($urandom_range(0, (1 << w) - 1));
        return r;
    endfunction

    function automatic in_t idle_in();
        in_t r;
        r.rst = 1'b0; r.clr = 1'b0; r.ld = 1'b0; r.en = 1'b0; r.ud = 1'b1; r.lv = 0;
        return r;
    endfunction

    initial begin
        in_a = idle_in(); in_b = idle_in(); in_c = idle_in(); in_k = idle_in();
        foreach (m_cnt[k]) begin m_cnt[k] = 0; m_done[k] = 1'b0; end

        // Reset everything.
        in_a.rst = 1'b1; in_b.rst = 1'b1; in_c.rst = 1'b1; in_k.rst = 1'b1;
        tick();
        in_a.rst = 1'b0; in_b.rst = 1'b0; in_c.rst = 1'b0; in_k.rst = 1'b0;
        check("reset_a", cnt_a, 0);
        check("reset_c", cnt_c, 5);
        check("reset_done_b", done_b, 0);

        // Wrap up: 1..9,0,1,2 with carry only at 9.
        in_a.en = 1'b1; in_a.ud = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("wrap_up", cnt_a, n % 10);
            check("wrap_up_carry", carry_a, (n % 10) == 9);
        end

        // Wrap down from reset: carry at 0, then 9,8,7 without carry.
        in_a.rst = 1'b1; tick(); in_a.rst = 1'b0;
        in_a.ud = 1'b0;
        #1 check("down_carry0", carry_a, 1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("wrap_down", cnt_a, 9 - n);
            check("wrap_down_carry", carry_a, 0);
        end

        // Priority and clamp.
        in_a.ud = 1'b1; in_a.clr = 1'b1; in_a.ld = 1'b1; in_a.lv = 5;
        tick();
        check("clr_over_load", cnt_a, 0);
        in_a.clr = 1'b0; in_a.lv = 12;
        tick();
        check("load_clamp", cnt_a, 9);
        in_a.ld = 1'b0; in_a.en = 1'b0;
        tick();
        check("hold_en0", cnt_a, 9);

        // Direction flip at the boundary.
        in_a.en = 1'b1; in_a.ud = 1'b0;
        #1 check("flip_carry", carry_a, 0);
        tick();
        check("flip_next", cnt_a, 8);
`ifdef MOD_COUNTER_SEG_DECODE_EN
        check("seg8", seg_a, 7'b0000000);
`endif
        in_a.clr = 1'b1; tick(); in_a.clr = 1'b0; in_a.en = 1'b0;
        check("clear0", cnt_a, 0);
`ifdef MOD_COUNTER_SEG_DECODE_EN
        check("seg0", seg_a, 7'b0000001);
`endif

        // One-shot: load 7, then 8, 9, 9+done, frozen, reload 3.
        in_b.ld = 1'b1; in_b.lv = 7; tick(); in_b.ld = 1'b0;
        check("os_load", cnt_b, 7);
        in_b.en = 1'b1; in_b.ud = 1'b1;
        tick(); check("os_8", cnt_b, 8);
        tick(); check("os_9", cnt_b, 9); check("os_done_pre", done_b, 0);
        tick(); check("os_hold", cnt_b, 9); check("os_done", done_b, 1);
        in_b.ud = 1'b0; tick(); check("os_frozen_dn", cnt_b, 9);
        in_b.ud = 1'b1; tick(); check("os_frozen_up", cnt_b, 9);
        check("os_done_stays", done_b, 1);
        in_b.ld = 1'b1; in_b.lv = 3; tick(); in_b.ld = 1'b0; in_b.en = 1'b0;
        check("os_reload", cnt_b, 3); check("os_done_clr", done_b, 0);

        // Cascade: 00..99 then 00, mid-count reset at 47.
        in_k.en = 1'b1; in_k.ud = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            check("cascade", cnt_hi * 10 + cnt_lo, n % 100);
            if (n == 99) begin
                check("casc_carry_lo99", carry_lo, 1);
                check("casc_carry_hi99", carry_hi, 1);
            end
        end
        for (int n = 1; n <= 47; n++) tick();
        check("casc_47", cnt_hi * 10 + cnt_lo, 47);
        in_k.rst = 1'b1;
        #1 check("casc_rst_carry", carry_lo, 0);
        tick();
        in_k.rst = 1'b0;
        check("casc_rst_lo", cnt_lo, 0);
        check("casc_rst_hi", cnt_hi, 0);

        // Randomised run against the model on all instances.
        for (int n = 0; n < 400; n++) begin
            in_a = rnd_in(4); in_b = rnd_in(4); in_c = rnd_in(3); in_k = rnd_in(4);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
